// File: rtl/bo_datapath.sv
// bo_datapath: operative block holding RX/RH/RS, one shared add/multiply ALU,
// a four-entry coefficient table and a sticky overflow flag.
module bo_datapath #(
  parameter int W  = 16,
  parameter int K0 = 3,
  parameter int K1 = 5,
  parameter int K2 = 7,
  parameter int K3 = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x_in,
  input  logic         LX,
  input  logic         LH,
  input  logic         LS,
  input  logic         H,
  input  logic [1:0]   M0,
  input  logic [1:0]   M1,
  input  logic [1:0]   M2,
  output logic [W-1:0] S,
  output logic [W-1:0] X,
  output logic [W-1:0] Hq,
  output logic         ovf,
  output logic         done
);

  localparam logic [W-1:0] K0_W = W'(K0);
  localparam logic [W-1:0] K1_W = W'(K1);
  localparam logic [W-1:0] K2_W = W'(K2);
  localparam logic [W-1:0] K3_W = W'(K3);

  logic [W-1:0]   rx_q, rx_d;
  logic [W-1:0]   rh_q, rh_d;
  logic [W-1:0]   rs_q, rs_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  logic [W-1:0]   coef;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [2*W-1:0] full;
  logic [W-1:0]   result;
  logic           wide;

  // Operand muxes and the shared ALU; the full-width result exposes overflow.
  always_comb begin
    coef = K0_W;
    case (M0)
      2'b00:   coef = K0_W;
      2'b01:   coef = K1_W;
      2'b10:   coef = K2_W;
      default: coef = K3_W;
    endcase

    op_a = '0;
    case (M1)
      2'b00:   op_a = rh_q;
      2'b01:   op_a = rx_q;
      2'b10:   op_a = rs_q;
      default: op_a = '0;
    endcase

    op_b = coef;
    case (M2)
      2'b00:   op_b = coef;
      2'b01:   op_b = rh_q;
      2'b10:   op_b = rs_q;
      default: op_b = rx_q;
    endcase

    if (H) begin
      full = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    end else begin
      full = {{W{1'b0}}, op_a} + {{W{1'b0}}, op_b};
    end
    result = full[W-1:0];
    wide   = |full[2*W-1:W];
  end

  // Next-state: independent loads, all fed from pre-edge register values.
  always_comb begin
    rx_d   = LX ? x_in   : rx_q;
    rh_d   = LH ? result : rh_q;
    rs_d   = LS ? result : rs_q;
    ovf_d  = ovf_q;
    if ((LH || LS) && wide) begin
      ovf_d = 1'b1;          // a wide load beats the clear from LX
    end else if (LX) begin
      ovf_d = 1'b0;          // new computation starts with a clean flag
    end
    done_d = LS;
  end

  // State registers; reset overrides every strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q   <= '0;
      rh_q   <= '0;
      rs_q   <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rx_q   <= rx_d;
      rh_q   <= rh_d;
      rs_q   <= rs_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign S    = rs_q;
  assign X    = rx_q;
  assign Hq   = rh_q;
  assign ovf  = ovf_q;
  assign done = done_q;

endmodule

// File: tb/tb_bo_datapath.sv
// Self-checking bench for bo_datapath: a directed vector table followed by
// randomized cycles compared against an arithmetic reference model.
module tb_bo_datapath;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] x_in;
  logic         LX, LH, LS, H;
  logic [1:0]   M0, M1, M2;
  logic [W-1:0] S, X, Hq;
  logic         ovf, done;

  int vectors;
  int errors;

  bo_datapath #(.W(W), .K0(3), .K1(5), .K2(7), .K3(2)) dut (
    .clk(clk), .reset(reset), .x_in(x_in),
    .LX(LX), .LH(LH), .LS(LS), .H(H),
    .M0(M0), .M1(M1), .M2(M2),
    .S(S), .X(X), .Hq(Hq), .ovf(ovf), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst, lx, lh, ls, h;
    logic [1:0]   m0, m1, m2;
    logic [W-1:0] x;
    logic [W-1:0] es, ex, eh;
    logic         eo, ed;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic lx, input logic lh,
                              input logic ls, input logic h, input logic [1:0] m0,
                              input logic [1:0] m1, input logic [1:0] m2,
                              input logic [W-1:0] x, input logic [W-1:0] es,
                              input logic [W-1:0] ex, input logic [W-1:0] eh,
                              input logic eo, input logic ed);
    vec_t v;
    v.rst = rst; v.lx = lx; v.lh = lh; v.ls = ls; v.h = h;
    v.m0 = m0; v.m1 = m1; v.m2 = m2; v.x = x;
    v.es = es; v.ex = ex; v.eh = eh; v.eo = eo; v.ed = ed;
    return v;
  endfunction

  // Drive one cycle, then compare all outputs just after the edge.
  task automatic apply(input string tag, input vec_t v);
    bit bad;
    reset = v.rst; LX = v.lx; LH = v.lh; LS = v.ls; H = v.h;
    M0 = v.m0; M1 = v.m1; M2 = v.m2; x_in = v.x;
    @(posedge clk);
    #1;
    vectors++;
    bad = (S !== v.es) || (X !== v.ex) || (Hq !== v.eh) || (ovf !== v.eo) || (done !== v.ed);
    if (bad) begin
      errors++;
      $display("FAIL %s: got S=%0d X=%0d Hq=%0d ovf=%0b done=%0b, want S=%0d X=%0d Hq=%0d ovf=%0b done=%0b",
               tag, S, X, Hq, ovf, done, v.es, v.ex, v.eh, v.eo, v.ed);
    end else begin
      $display("ok   %s: S=%0d X=%0d Hq=%0d ovf=%0b done=%0b", tag, S, X, Hq, ovf, done);
    end
  endtask

  vec_t tbl[21];

  // Reference model state (plain integers).
  longint unsigned m_rx, m_rh, m_rs;
  bit              m_ovf, m_done;

  initial begin
    vectors = 0;
    errors  = 0;
    reset = 1'b0; LX = 0; LH = 0; LS = 0; H = 0;
    M0 = 0; M1 = 0; M2 = 0; x_in = '0;

    //            rst lx lh ls h  m0 m1 m2  x       S      X      Hq     ovf done
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 9,     0,     0,     0,     0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 4,     0,     4,     0,     0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 1, 0, 1, 0, 0,     0,     4,     12,    0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 0, 0, 0, 3, 0,     16,    4,     12,    0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 1, 2, 3, 1, 77,    16,    4,     12,    0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 300,   16,    300,   12,    0, 0);
    tbl[6]  = mk(0, 0, 1, 0, 1, 0, 1, 3, 0,     16,    300,   24464, 1, 0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 2,     16,    2,     24464, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 0, 1, 0, 0,     16,    2,     5,     0, 0);
    tbl[9]  = mk(0, 1, 1, 1, 1, 0, 1, 1, 7,     10,    7,     10,    0, 1);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 0, 0, 4,     10,    4,     10,    0, 0);
    tbl[11] = mk(0, 0, 1, 0, 1, 0, 1, 0, 0,     10,    4,     12,    0, 0);
    tbl[12] = mk(1, 0, 0, 1, 0, 0, 0, 3, 0,     0,     0,     0,     0, 0);
    tbl[13] = mk(0, 1, 0, 0, 0, 0, 0, 0, 4,     0,     4,     0,     0, 0);
    tbl[14] = mk(0, 0, 1, 0, 1, 0, 1, 0, 0,     0,     4,     12,    0, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 0, 65535, 0,     65535, 12,    0, 0);
    tbl[16] = mk(0, 1, 1, 0, 0, 0, 1, 1, 1,     0,     1,     11,    1, 0);
    tbl[17] = mk(0, 0, 0, 1, 0, 1, 3, 0, 0,     5,     1,     11,    1, 1);
    tbl[18] = mk(0, 0, 0, 1, 0, 2, 3, 0, 0,     7,     1,     11,    1, 1);
    tbl[19] = mk(0, 0, 0, 1, 0, 3, 3, 0, 0,     2,     1,     11,    1, 1);
    tbl[20] = mk(0, 0, 0, 0, 1, 1, 2, 2, 5,     2,     1,     11,    1, 0);

    for (int i = 0; i < 21; i++) begin
      apply($sformatf("dir%0d", i), tbl[i]);
    end

    // Hand sequence: done pulse lasts one cycle even with LS back-to-back then idle.
    m_rx = 1; m_rh = 11; m_rs = 2; m_ovf = 1; m_done = 0;

    // Randomized run against the model.
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      longint unsigned a_opts[4];
      longint unsigned b_opts[4];
      longint unsigned kc[4];
      longint unsigned a, b, full, res;
      bit wide;

      v.rst = ($urandom_range(0, 31) == 0);
      v.lx  = $urandom_range(0, 1);
      v.lh  = $urandom_range(0, 1);
      v.ls  = $urandom_range(0, 2) == 0;
      v.h   = $urandom_range(0, 1);
      v.m0  = 2'($urandom_range(0, 3));
      v.m1  = 2'($urandom_range(0, 3));
      v.m2  = 2'($urandom_range(0, 3));
      v.x   = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 400));

      kc = '{3, 5, 7, 2};
      a_opts = '{m_rh, m_rx, m_rs, 0};
      b_opts = '{kc[v.m0], m_rh, m_rs, m_rx};
      a = a_opts[v.m1];
      b = b_opts[v.m2];
      full = v.h ? a * b : a + b;
      res  = full % 65536;
      wide = (full > 65535);

      if (v.rst) begin
        m_rx = 0; m_rh = 0; m_rs = 0; m_ovf = 0; m_done = 0;
      end else begin
        if ((v.lh || v.ls) && wide) m_ovf = 1;
        else if (v.lx)              m_ovf = 0;
        if (v.lx) m_rx = v.x;
        if (v.lh) m_rh = res;
        if (v.ls) m_rs = res;
        m_done = v.ls;
      end

      v.es = W'(m_rs); v.ex = W'(m_rx); v.eh = W'(m_rh);
      v.eo = m_ovf;    v.ed = m_done;
      apply($sformatf("rnd%0d", n), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
